spart_driver: RTL and testbench
===============================

Name: spart_driver

Overview:
- Processor-side initiator for the mini SPART register bus; stands in for the CPU on the lab board.
- After reset it programs the baud divisor from board switches, then runs an echo loop: poll status, read each received byte, wait for transmitter ready, write the byte back.
- It drives iocs/iorw/ioaddr/databus toward the SPART bus interface and samples the read data returned on the same bus.

Parameters:
- DIV0, 16'h0515, divisor for br_cfg=00 (4800 baud at 100 MHz, 16x oversample)
- DIV1, 16'h028A, divisor for br_cfg=01 (9600)
- DIV2, 16'h0145, divisor for br_cfg=10 (19200)
- DIV3, 16'h00A2, divisor for br_cfg=11 (38400)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- br_cfg  in  2  baud select switches; asynchronous to clk, double-flopped internally
- iocs  out  1  bus chip select; one-cycle access when high
- iorw  out  1  1 = read, 0 = write
- ioaddr  out  2  00 rx/tx buffer, 01 status {6'b0,rda,tbr}, 10 divisor low, 11 divisor high
- bus_wdata  out  8  write data to SPART
- bus_rdata  in  8  read data from SPART; combinational, valid in the cycle iocs&iorw is high
- rx_char  out  8  last byte read from the receive buffer
- rx_strobe  out  1  one-cycle pulse when rx_char updates
- echo_cnt  out  8  count of bytes echoed; wraps 255->0

Behaviour:
- Interface: one clock; reset is synchronous and active-low, ports clk and rst_n.
- Reset (rst_n=0 at a clock edge): state=INIT_LO, iocs=0, iorw=1, ioaddr=00, bus_wdata=00, rx_char=00, rx_strobe=0, echo_cnt=00. The latched configuration cfg_q takes the synchronized br_cfg.
- Bus outputs are registered. Every access lasts exactly one cycle. iocs is never held high for two consecutive cycles. Every access is followed by at least one idle cycle with iocs=0.
- In each access cycle, read data is sampled at the closing clock edge.
- Divisor: div = DIVn selected by cfg_q.
- States and transitions (each state issues one access, then passes through an idle gap cycle):
  - INIT_LO: write ioaddr=10, bus_wdata=div[7:0] -> INIT_HI.
  - INIT_HI: write ioaddr=11, bus_wdata=div[15:8] -> POLL_RX.
  - POLL_RX: read ioaddr=01. If bus_rdata[1] (rda)=1 -> READ_RX, else stay in POLL_RX.
  - READ_RX: read ioaddr=00. Capture bus_rdata into rx_char, pulse rx_strobe on the following cycle -> POLL_TX.
  - POLL_TX: read ioaddr=01. If bus_rdata[0] (tbr)=1 -> WRITE_TX, else stay in POLL_TX.
  - WRITE_TX: write ioaddr=00, bus_wdata=rx_char. Increment echo_cnt -> POLL_RX.
- Reconfiguration: if the synchronized br_cfg differs from cfg_q when in POLL_RX (at the decision edge), load cfg_q and go to INIT_LO; the status read result is discarded. The change is not acted on in other states; it is honoured at the next POLL_RX.
- Status bits 7:2 are ignored.
- iorw=0 is always driven for addresses 10 and 11.
- No timeout: POLL_TX waits indefinitely for tbr.
- A reset in any state, including an access cycle, immediately returns all outputs to reset values at that edge. No partial access persists.

Test Plan:
- Reset release with br_cfg=01 -> write 10/8'h8A, idle cycle, write 11/8'h02, then status reads at ioaddr=01 every other cycle, iocs never high two cycles in a row.
- Status model returns rda=1, rx buffer returns 8'h41 -> read at 00, rx_strobe one cycle with rx_char=8'h41. With tbr=1, write 00/8'h41 follows and echo_cnt=1.
- tbr held 0 for 20 cycles after rx read -> repeated reads of 01 only, no write to 00. Raise tbr -> exactly one write of 8'h41.
- br_cfg changes 01->11 while polling -> after sync latency, writes 10/8'hA2 then 11/8'h00, then polling resumes. A change during POLL_TX is deferred until after WRITE_TX.
- rst_n=0 during WRITE_TX access cycle -> at that edge iocs=0, echo_cnt=0, state INIT_LO. Divisor is rewritten after release.
- 256 echoed bytes -> echo_cnt wraps to 8'h00. rx_char tracks each byte: 8'h00, 8'hFF, and 8'h55 patterns echoed verbatim.

Source files
------------

// File: rtl/spart_driver_if.sv
// Register bus between the processor-side driver and the SPART.
// The driver is the master; the SPART returns combinational read data.
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;

    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/spart_driver.sv
// Processor stand-in for the mini SPART bus: programs the baud divisor
// from the switches, then echoes every received byte back out.
module spart_driver #(
    parameter logic [15:0] DIV0 = 16'h0515,
    parameter logic [15:0] DIV1 = 16'h028A,
    parameter logic [15:0] DIV2 = 16'h0145,
    parameter logic [15:0] DIV3 = 16'h00A2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     br_cfg,
    spart_driver_if.master bus,
    output logic [7:0]     rx_char,
    output logic           rx_strobe,
    output logic [7:0]     echo_cnt
);

    localparam logic [2:0] INIT_LO  = 3'd0;
    localparam logic [2:0] INIT_HI  = 3'd1;
    localparam logic [2:0] POLL_RX  = 3'd2;
    localparam logic [2:0] READ_RX  = 3'd3;
    localparam logic [2:0] POLL_TX  = 3'd4;
    localparam logic [2:0] WRITE_TX = 3'd5;

    localparam logic [1:0] A_BUF    = 2'b00;
    localparam logic [1:0] A_STAT   = 2'b01;
    localparam logic [1:0] A_DIV_LO = 2'b10;
    localparam logic [1:0] A_DIV_HI = 2'b11;

    logic [1:0]  cfg_s1;
    logic [1:0]  cfg_s2;
    logic [1:0]  cfg_q;
    logic [2:0]  state;
    logic [15:0] div;

    // Switches are asynchronous; two flops before anything looks at them.
    always_ff @(posedge clk) begin
        cfg_s1 <= br_cfg;
        cfg_s2 <= cfg_s1;
    end

    always_comb begin
        div = DIV0;
        unique case (cfg_q)
            2'b00: div = DIV0;
            2'b01: div = DIV1;
            2'b10: div = DIV2;
            2'b11: div = DIV3;
            default: div = DIV0;
        endcase
    end

    // iocs low: issue this state's access. iocs high: close it and decide.
    // Closing always drops iocs, which gives the mandatory idle gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= INIT_LO;
            bus.iocs      <= 1'b0;
            bus.iorw      <= 1'b1;
            bus.ioaddr    <= A_BUF;
            bus.bus_wdata <= 8'h00;
            rx_char       <= 8'h00;
            rx_strobe     <= 1'b0;
            echo_cnt      <= 8'h00;
            cfg_q         <= cfg_s2;
        end else begin
            rx_strobe <= 1'b0;
            if (!bus.iocs) begin
                bus.iocs <= 1'b1;
                unique case (state)
                    INIT_LO: begin
                        bus.iorw      <= 1'b0;
                        bus.ioaddr    <= A_DIV_LO;
                        bus.bus_wdata <= div[7:0];
                    end
                    INIT_HI: begin
                        bus.iorw      <= 1'b0;
                        bus.ioaddr    <= A_DIV_HI;
                        bus.bus_wdata <= div[15:8];
                    end
                    POLL_RX, POLL_TX: begin
                        bus.iorw   <= 1'b1;
                        bus.ioaddr <= A_STAT;
                    end
                    READ_RX: begin
                        bus.iorw   <= 1'b1;
                        bus.ioaddr <= A_BUF;
                    end
                    WRITE_TX: begin
                        bus.iorw      <= 1'b0;
                        bus.ioaddr    <= A_BUF;
                        bus.bus_wdata <= rx_char;
                    end
                    default: begin
                        bus.iocs <= 1'b0;
                        state    <= INIT_LO;
                    end
                endcase
            end else begin
                bus.iocs <= 1'b0;
                unique case (state)
                    INIT_LO: state <= INIT_HI;
                    INIT_HI: state <= POLL_RX;
                    POLL_RX: begin
                        if (cfg_s2 != cfg_q) begin
                            cfg_q <= cfg_s2;
                            state <= INIT_LO;
                        end else if (bus.bus_rdata[1]) begin
                            state <= READ_RX;
                        end
                    end
                    READ_RX: begin
                        rx_char   <= bus.bus_rdata;
                        rx_strobe <= 1'b1;
                        state     <= POLL_TX;
                    end
                    POLL_TX: begin
                        if (bus.bus_rdata[0]) begin
                            state <= WRITE_TX;
                        end
                    end
                    WRITE_TX: begin
                        echo_cnt <= echo_cnt + 8'd1;
                        state    <= POLL_RX;
                    end
                    default: state <= INIT_LO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a SPART bus model feeds bytes and status, and a
// transaction scoreboard checks the echo protocol and divisor programming.
module tb_spart_driver;

    logic       clk;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic [7:0] rx_char;
    logic       rx_strobe;
    logic [7:0] echo_cnt;

    spart_driver_if bus ();

    spart_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .br_cfg    (br_cfg),
        .bus       (bus.master),
        .rx_char   (rx_char),
        .rx_strobe (rx_strobe),
        .echo_cnt  (echo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus-owned: bytes waiting in the SPART receiver and tbr level.
    logic [7:0] feed [0:511];
    int         feed_n = 0;
    logic       tbr = 1'b0;

    // Monitor-owned: model state and transaction counters.
    int         rd_idx = 0;
    logic [5:0] junk = 6'd0;
    logic [7:0] exp_q [$];
    int         exp_next = 1;
    int         model_cnt = 0;
    logic       pend_pop = 1'b0;
    logic       pend_w = 1'b0;
    logic [7:0] last_rd = 8'h00;
    logic       last_rda = 1'b0;
    logic       last_tbr = 1'b0;
    logic       in_echo = 1'b0;
    logic       prev_iocs = 1'b0;
    int         div_cnt = 0;
    int         st_cnt = 0;
    int         rd00_cnt = 0;
    int         w00_cnt = 0;

    logic       rx_avail;
    logic [7:0] rx_head;
    assign rx_avail = (rd_idx < feed_n);
    assign rx_head  = feed[rd_idx[8:0]];
    assign bus.bus_rdata = (bus.ioaddr == 2'b01) ?
        {junk, rx_avail, tbr} : rx_head;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] div_of(input logic [1:0] c);
        case (c)
            2'b00: return 16'h0515;
            2'b01: return 16'h028A;
            2'b10: return 16'h0145;
            default: return 16'h00A2;
        endcase
    endfunction

    function automatic int cnt(input int sel);
        case (sel)
            0: return div_cnt;
            1: return st_cnt;
            2: return rd00_cnt;
            default: return w00_cnt;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input string tag, input int sel,
                            input int target, input int lim);
        int i;
        i = 0;
        while (cnt(sel) < target && i < lim) begin
            tick();
            i++;
        end
        chk(tag, 16'(cnt(sel) >= target), 16'd1);
    endtask

    task automatic push(input logic [7:0] b);
        feed[feed_n[8:0]] = b;
        feed_n++;
    endtask

    // Bus monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [2:0]  acc;
        logic [15:0] d;
        if (!rst_n) begin
            chk("rst_iocs", 16'(bus.iocs), 16'd0);
            chk("rst_iorw", 16'(bus.iorw), 16'd1);
            chk("rst_addr", 16'(bus.ioaddr), 16'd0);
            chk("rst_wdata", 16'(bus.bus_wdata), 16'd0);
            chk("rst_rxchar", 16'(rx_char), 16'd0);
            chk("rst_strobe", 16'(rx_strobe), 16'd0);
            chk("rst_echo", 16'(echo_cnt), 16'd0);
            exp_q.delete();
            exp_next = 1;
            model_cnt = 0;
            pend_w = 1'b0;
            if (pend_pop) rd_idx++;
            pend_pop = 1'b0;
            last_rda = 1'b0;
            last_tbr = 1'b0;
            in_echo = 1'b0;
            prev_iocs = 1'b0;
        end else begin
            if (pend_pop) begin
                rd_idx++;
                chk("rx_char", 16'(rx_char), 16'(last_rd));
            end
            if (rx_strobe != pend_pop)
                chk("strobe", 16'(rx_strobe), 16'(pend_pop));
            if (pend_w)
                chk("echo_cnt", 16'(echo_cnt), 16'(model_cnt[7:0]));
            pend_pop = 1'b0;
            pend_w = 1'b0;
            if (bus.iocs) begin
                chk("gap", 16'(prev_iocs), 16'd0);
                acc = {bus.iorw, bus.ioaddr};
                if (exp_next == 1) chk("seq_lo", 16'(acc), 16'h2);
                else if (exp_next == 2) chk("seq_hi", 16'(acc), 16'h3);
                else if (exp_next == 3) chk("seq_poll", 16'(acc), 16'h5);
                d = div_of(br_cfg);
                case (acc)
                    3'b010: begin
                        chk("div_lo", 16'(bus.bus_wdata), 16'(d[7:0]));
                        chk("defer", 16'(in_echo), 16'd0);
                        exp_next = 2;
                        div_cnt++;
                    end
                    3'b011: begin
                        chk("div_hi", 16'(bus.bus_wdata), 16'(d[15:8]));
                        exp_next = 3;
                        div_cnt++;
                    end
                    3'b101: begin
                        last_rda = bus.bus_rdata[1];
                        last_tbr = bus.bus_rdata[0];
                        exp_next = 0;
                        st_cnt++;
                    end
                    3'b100: begin
                        chk("rda", 16'(last_rda), 16'd1);
                        last_rda = 1'b0;
                        last_rd = bus.bus_rdata;
                        exp_q.push_back(bus.bus_rdata);
                        pend_pop = 1'b1;
                        in_echo = 1'b1;
                        rd00_cnt++;
                    end
                    3'b000: begin
                        chk("tbr", 16'(last_tbr), 16'd1);
                        last_tbr = 1'b0;
                        if (exp_q.size() > 0)
                            chk("echo", 16'(bus.bus_wdata), 16'(exp_q.pop_front()));
                        else
                            chk("echo_none", 16'(exp_q.size()), 16'd1);
                        model_cnt++;
                        pend_w = 1'b1;
                        in_echo = 1'b0;
                        w00_cnt++;
                    end
                    default: chk("bad_acc", 16'(acc), 16'h5);
                endcase
            end else begin
                junk = 6'($urandom);
            end
            prev_iocs = bus.iocs;
        end
    end

    initial begin
        int base;
        int s0;
        int hit;
        rst_n  = 1'b0;
        br_cfg = 2'b01;
        tbr    = 1'b0;
        repeat (4) tick();
        rst_n = 1'b1;

        // Divisor for 9600 baud, then status polling.
        wait_for("init_div", 0, 2, 20);
        wait_for("init_poll", 1, 3, 20);

        // First echo of 8'h41.
        tbr = 1'b1;
        push(8'h41);
        wait_for("echo1", 3, 1, 60);
        repeat (2) tick();
        chk("rx41", 16'(rx_char), 16'h41);
        chk("cnt1", 16'(echo_cnt), 16'd1);

        // Transmitter busy: only status polls until tbr returns.
        tbr = 1'b0;
        base = w00_cnt;
        push(8'h41);
        wait_for("stall_rd", 2, rd00_cnt + 1, 60);
        s0 = st_cnt;
        repeat (20) tick();
        chk("stall_w", 16'(w00_cnt), 16'(base));
        chk("stall_poll", 16'(st_cnt - s0 >= 9), 16'd1);
        tbr = 1'b1;
        wait_for("stall_go", 3, base + 1, 20);
        repeat (10) tick();
        chk("stall_one", 16'(w00_cnt), 16'(base + 1));

        // Reconfiguration while idle polling.
        base = div_cnt;
        br_cfg = 2'b11;
        wait_for("recfg", 0, base + 2, 40);
        s0 = st_cnt;
        repeat (10) tick();
        chk("resume", 16'(st_cnt > s0), 16'd1);

        // Change during POLL_TX waits for the echo to finish.
        tbr = 1'b0;
        push(8'h5A);
        wait_for("def_rd", 2, rd00_cnt + 1, 60);
        br_cfg = 2'b10;
        base = div_cnt;
        s0 = w00_cnt;
        repeat (20) tick();
        chk("def_hold", 16'(div_cnt), 16'(base));
        tbr = 1'b1;
        wait_for("def_div", 0, base + 2, 40);
        chk("def_echo", 16'(w00_cnt), 16'(s0 + 1));

        // Reset landing in a WRITE_TX access cycle.
        push(8'h77);
        hit = 0;
        for (int i = 0; i < 200 && hit == 0; i++) begin
            @(negedge clk);
            #1;
            if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) begin
                rst_n = 1'b0;
                hit = 1;
            end
        end
        chk("rst_hit", 16'(hit), 16'd1);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        base = div_cnt;
        wait_for("rst_div", 0, base + 2, 20);

        // 256 echoes from reset: counter wraps, patterns verbatim.
        base = w00_cnt;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        for (int i = 0; i < 253; i++) push(8'($urandom));
        for (int i = 0; i < 30000 && w00_cnt < base + 256; i++) begin
            tick();
            tbr = ($urandom_range(3) != 0);
        end
        chk("wrap_done", 16'(w00_cnt >= base + 256), 16'd1);
        tbr = 1'b1;
        repeat (4) tick();
        chk("wrap", 16'(echo_cnt), 16'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
